// File: rtl/region_draw_scanner.sv
// region_draw_scanner: walks a screen region in raster order, issuing ROM addresses and plotting
// latency-aligned pixels with off-screen clipping and optional colour keying.
module region_draw_scanner #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int ADDR_W = 15,
  parameter int COLOUR_W = 3,
  parameter int READ_LATENCY = 1,
  parameter int TRANSPARENT_EN = 0,
  parameter int TRANSPARENT_COLOUR = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                full_screen,
  input  logic [X_W-1:0]      rect_x,
  input  logic [Y_W-1:0]      rect_y,
  input  logic [X_W-1:0]      rect_w,
  input  logic [Y_W-1:0]      rect_h,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  localparam int L = READ_LATENCY;
  localparam int DW = $clog2(L + 2);
  localparam logic [X_W:0] SW = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SH = (Y_W + 1)'(SCREEN_H);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [X_W-1:0] rx, rw, cx;
  logic [Y_W-1:0] ry, rh, cy;
  logic [DW-1:0] dcnt;
  logic accept, zero, row_end, last, key;
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  logic [L-1:0] pv, pc;
  logic [X_W-1:0] px [L];
  logic [Y_W-1:0] py [L];
  assign accept = start && (state == IDLE || state == DONE);
  assign zero = !full_screen && (rect_w == '0 || rect_h == '0);
  assign row_end = cx == rw - X_W'(1);
  assign last = row_end && cy == rh - Y_W'(1);
  assign sx = {1'b0, rx} + {1'b0, cx};
  assign sy = {1'b0, ry} + {1'b0, cy};
  assign key = TRANSPARENT_EN != 0 && rom_data == COLOUR_W'(TRANSPARENT_COLOUR);
  assign busy = state == SCAN || state == DRAIN;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? (zero ? DONE : SCAN) : IDLE;
      SCAN:       state_nx = last ? DRAIN : SCAN;
      DRAIN:      state_nx = dcnt == DW'(L) ? DONE : DRAIN;
      default:    state_nx = IDLE;
    endcase
  end
  // The counters and rom_addr describe the pixel issued this cycle; the pipeline carries it to the ROM output.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      {rx, ry, rw, rh, cx, cy, dcnt, rom_addr} <= '0;
      pv <= '0;
      pc <= '0;
      for (int i = 0; i < L; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
      {x, y, colour, plot} <= '0;
    end else begin
      state <= state_nx;
      dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
      if (accept) begin
        rx <= full_screen ? '0 : rect_x;
        ry <= full_screen ? '0 : rect_y;
        rw <= full_screen ? X_W'(SCREEN_W) : rect_w;
        rh <= full_screen ? Y_W'(SCREEN_H) : rect_h;
        {cx, cy} <= '0;
        rom_addr <= base_addr;
      end else if (state == SCAN && !last) begin
        cx <= row_end ? '0 : cx + X_W'(1);
        cy <= row_end ? cy + Y_W'(1) : cy;
        rom_addr <= rom_addr + ADDR_W'(1);
      end
      pv[0] <= state == SCAN;
      pc[0] <= sx >= SW || sy >= SH;
      px[0] <= sx[X_W-1:0];
      py[0] <= sy[Y_W-1:0];
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pc[i] <= pc[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
      plot <= pv[L-1] && !pc[L-1] && !key;
      if (pv[L-1]) begin
        x <= px[L-1];
        y <= py[L-1];
        colour <= rom_data;
      end
    end
endmodule

// File: tb/tb_region_draw_scanner.sv
// tb_region_draw_scanner: two scanners (L=1 plain, L=2 keyed on colour 0) driven in parallel and
// compared against a raster-order reference model of plots, done timing and busy length.
module tb_region_draw_scanner;
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } rec_t;

  logic clk = 0;
  logic resetn, start, full_screen;
  logic [7:0] rect_x, rect_w;
  logic [6:0] rect_y, rect_h;
  logic [14:0] base_addr, ra0, ra1;
  logic [2:0] rd0, rd1, r1a, col0, col1;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic plot0, plot1, busy0, busy1, done0, done1;

  logic [2:0] rom_mem [0:32767];
  rec_t mon0[$], mon1[$], exp0[$], exp1[$];
  int cyc = 0;
  int done_cnt [2];
  int done_cyc [2];
  int busy_cnt [2];
  int n_chk = 0, n_err = 0;

  region_draw_scanner u0 (
    .clk(clk), .resetn(resetn), .start(start), .full_screen(full_screen),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .base_addr(base_addr), .rom_addr(ra0), .rom_data(rd0),
    .x(x0), .y(y0), .colour(col0), .plot(plot0), .busy(busy0), .done(done0)
  );

  region_draw_scanner #(.READ_LATENCY(2), .TRANSPARENT_EN(1), .TRANSPARENT_COLOUR(0)) u1 (
    .clk(clk), .resetn(resetn), .start(start), .full_screen(full_screen),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .base_addr(base_addr), .rom_addr(ra1), .rom_data(rd1),
    .x(x1), .y(y1), .colour(col1), .plot(plot1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd0 <= rom_mem[ra0];
    r1a <= rom_mem[ra1];
    rd1 <= r1a;
  end

  always @(negedge clk) begin
    if (plot0) mon0.push_back(rec_t'({cyc, x0, y0, col0}));
    if (plot1) mon1.push_back(rec_t'({cyc, x1, y1, col1}));
    if (done0) begin done_cnt[0]++; done_cyc[0] = cyc; end
    if (done1) begin done_cnt[1]++; done_cyc[1] = cyc; end
    if (busy0) busy_cnt[0]++;
    if (busy1) busy_cnt[1]++;
  end

  task automatic clear_stats;
    mon0.delete();
    mon1.delete();
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0;
      done_cyc[d] = -1;
      busy_cnt[d] = 0;
    end
  endtask

  // Reference: every pixel of the region in raster order, plot k due L+1 cycles after its address.
  task automatic build_exp(input bit full, input int rx, ry, rw, rh, base, c0);
    exp0.delete();
    exp1.delete();
    if (full) begin rx = 0; ry = 0; rw = 160; rh = 120; end
    for (int k = 0; k < rw * rh; k++) begin
      int sx = rx + k % rw;
      int sy = ry + k / rw;
      logic [2:0] col = rom_mem[(base + k) % 32768];
      if (sx < 160 && sy < 120) begin
        exp0.push_back(rec_t'({32'(c0 + k + 2), 8'(sx), 7'(sy), col}));
        if (col != 0) exp1.push_back(rec_t'({32'(c0 + k + 3), 8'(sx), 7'(sy), col}));
      end
    end
  endtask

  function automatic string fmt(input rec_t r);
    return $sformatf("(%0d,%0d) c%0d @%0d", r.x, r.y, r.c, r.cyc);
  endfunction

  function automatic int plot_diff(input int d, output string msg);
    int n = d ? mon1.size() : mon0.size();
    int m = d ? exp1.size() : exp0.size();
    int bad = 0;
    msg = "";
    if (n != m) begin
      bad++;
      msg = $sformatf("count got %0d want %0d", n, m);
    end
    for (int i = 0; i < n && i < m; i++) begin
      rec_t a = d ? mon1[i] : mon0[i];
      rec_t e = d ? exp1[i] : exp0[i];
      if (a !== e) begin
        if (bad == 0) msg = $sformatf("#%0d got %s want %s", i, fmt(a), fmt(e));
        bad++;
      end
    end
    return bad;
  endfunction

  task automatic scan(input string nm, input bit full, input int rx, ry, rw, rh, base,
                      input bit hold, output int c0, output int n);
    clear_stats();
    @(negedge clk);
    full_screen = full;
    rect_x = 8'(rx); rect_y = 7'(ry); rect_w = 8'(rw); rect_h = 7'(rh);
    base_addr = 15'(base);
    start = 1;
    @(posedge clk);
    #1;
    c0 = cyc;
    n = full ? 19200 : rw * rh;
    if (!hold) start = 0;
    rect_x = 8'($urandom); rect_y = 7'($urandom); rect_w = 8'($urandom); rect_h = 7'($urandom);
    full_screen = 1'($urandom);
    base_addr = 15'($urandom);
    build_exp(full, rx, ry, rw, rh, base, c0);
    for (int i = 0; i < n + 40 && !(done_cnt[0] > 0 && done_cnt[1] > 0); i++) begin
      @(negedge clk);
      if (hold && cyc >= c0 + n) start = 0;
    end
    start = 0;
    n_chk++;
    if (!(done_cnt[0] > 0 && done_cnt[1] > 0)) begin
      n_err++;
      $display("FAIL %s timeout: done pulses got %0d/%0d want 1/1", nm, done_cnt[0], done_cnt[1]);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 0;
    start = 1; full_screen = 1; rect_x = 8'd33; rect_y = 7'd9; rect_w = 8'd5; rect_h = 7'd5;
    base_addr = 15'd777;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ra0, x0, y0, col0, plot0, busy0, done0} !== '0) begin
      n_err++;
      $display("FAIL reset dut0 outputs got %h want 0", {ra0, x0, y0, col0, plot0, busy0, done0});
    end
    n_chk++;
    if ({ra1, x1, y1, col1, plot1, busy1, done1} !== '0) begin
      n_err++;
      $display("FAIL reset dut1 outputs got %h want 0", {ra1, x1, y1, col1, plot1, busy1, done1});
    end
    start = 0;
    resetn = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy0, busy1, plot0, plot1, done0, done1} !== '0) begin
      n_err++;
      $display("FAIL idle after reset got %b want 000000", {busy0, busy1, plot0, plot1, done0, done1});
    end
  endtask

  task automatic test_full_screen;
    int c0, n, bad;
    string msg;
    scan("full", 1, 7, 3, 9, 9, 0, 0, c0, n);
    for (int d = 0; d < 2; d++) begin
      bad = plot_diff(d, msg);
      n_chk++;
      if (bad !== 0) begin n_err++; $display("FAIL full dut%0d plots: %s", d, msg); end
      n_chk++;
      if (done_cnt[d] !== 1 || done_cyc[d] !== c0 + n + d + 2) begin
        n_err++;
        $display("FAIL full dut%0d done: got %0d at %0d want 1 at %0d", d, done_cnt[d], done_cyc[d], c0 + n + d + 2);
      end
      n_chk++;
      if (busy_cnt[d] !== n + d + 2) begin
        n_err++;
        $display("FAIL full dut%0d busy cycles got %0d want %0d", d, busy_cnt[d], n + d + 2);
      end
    end
    n_chk++;
    if (ra0 !== 15'd19199 || ra1 !== 15'd19199) begin
      n_err++;
      $display("FAIL full final rom_addr got %0d/%0d want 19199", ra0, ra1);
    end
  endtask

  task automatic test_rect;
    int c0, n, bad;
    string msg;
    scan("rect", 0, 10, 5, 3, 2, 100, 0, c0, n);
    for (int d = 0; d < 2; d++) begin
      bad = plot_diff(d, msg);
      n_chk++;
      if (bad !== 0) begin n_err++; $display("FAIL rect dut%0d plots: %s", d, msg); end
      n_chk++;
      if (done_cnt[d] !== 1 || done_cyc[d] !== c0 + n + d + 2) begin
        n_err++;
        $display("FAIL rect dut%0d done: got %0d at %0d want 1 at %0d", d, done_cnt[d], done_cyc[d], c0 + n + d + 2);
      end
    end
    n_chk++;
    if (rom_mem[100] != 0 && (mon1.size() == 0 || mon1[0].cyc !== 32'(c0 + 3) || mon1[0].x !== 8'd10 || mon1[0].y !== 7'd5)) begin
      n_err++;
      $display("FAIL rect dut1 first plot got %0d entries, want (10,5) @%0d", mon1.size(), c0 + 3);
    end
  endtask

  task automatic test_clip;
    int c0, n, bad;
    string msg;
    scan("clip", 0, 158, 118, 4, 4, 4000, 0, c0, n);
    n_chk++;
    if (mon0.size() !== 4 || mon0[0].x !== 8'd158 || mon0[3].y !== 7'd119) begin
      n_err++;
      $display("FAIL clip dut0 plots got %0d want 4 from (158,118) to (159,119)", mon0.size());
    end
    for (int d = 0; d < 2; d++) begin
      bad = plot_diff(d, msg);
      n_chk++;
      if (bad !== 0) begin n_err++; $display("FAIL clip dut%0d plots: %s", d, msg); end
      n_chk++;
      if (done_cnt[d] !== 1 || done_cyc[d] !== c0 + 16 + d + 2 || busy_cnt[d] !== 16 + d + 2) begin
        n_err++;
        $display("FAIL clip dut%0d done: got %0d at %0d busy %0d want 1 at %0d busy %0d",
                 d, done_cnt[d], done_cyc[d], busy_cnt[d], c0 + 18 + d, 18 + d);
      end
    end
    n_chk++;
    if (ra0 !== 15'd4015) begin n_err++; $display("FAIL clip last rom_addr got %0d want 4015", ra0); end
  endtask

  task automatic test_transparent;
    int c0, n, bad;
    string msg;
    rom_mem[200] = 3'd0; rom_mem[201] = 3'd5; rom_mem[202] = 3'd0; rom_mem[203] = 3'd7;
    scan("key", 0, 50, 50, 4, 1, 200, 0, c0, n);
    n_chk++;
    if (mon1.size() != 2) begin
      n_err++;
      $display("FAIL key dut1 plot count got %0d want 2", mon1.size());
    end else if (mon1[0].x !== 8'd51 || mon1[0].c !== 3'd5 || mon1[1].x !== 8'd53 || mon1[1].c !== 3'd7) begin
      n_err++;
      $display("FAIL key dut1 plots got %s %s want (51,50) c5, (53,50) c7", fmt(mon1[0]), fmt(mon1[1]));
    end
    bad = plot_diff(0, msg);
    n_chk++;
    if (bad !== 0) begin n_err++; $display("FAIL key dut0 plots: %s", msg); end
  endtask

  task automatic test_zero;
    int c0, n;
    for (int t = 0; t < 2; t++) begin
      scan("zero", 0, 20, 20, t ? 6 : 0, t ? 0 : 6, 50, 0, c0, n);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if ((d ? mon1.size() : mon0.size()) !== 0 || done_cnt[d] !== 1 || done_cyc[d] !== c0 || busy_cnt[d] !== 0) begin
          n_err++;
          $display("FAIL zero%0d dut%0d: plots %0d done %0d at %0d busy %0d want 0, 1 at %0d, 0",
                   t, d, d ? mon1.size() : mon0.size(), done_cnt[d], done_cyc[d], busy_cnt[d], c0);
        end
      end
    end
  endtask

  task automatic test_start_held;
    int c0, n, bad;
    string msg;
    scan("held", 0, 30, 40, 5, 3, 1000, 1, c0, n);
    for (int d = 0; d < 2; d++) begin
      bad = plot_diff(d, msg);
      n_chk++;
      if (bad !== 0 || done_cnt[d] !== 1 || busy_cnt[d] !== n + d + 2) begin
        n_err++;
        $display("FAIL held dut%0d: plots '%s' done %0d busy %0d want 1 done busy %0d", d, msg, done_cnt[d], busy_cnt[d], n + d + 2);
      end
    end
  endtask

  task automatic test_back_to_back;
    clear_stats();
    @(negedge clk);
    full_screen = 0; rect_x = 8'd20; rect_y = 7'd20; rect_w = 8'd3; rect_h = 7'd2; base_addr = 15'd300;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 40 && !done0; i++) @(negedge clk);
    n_chk++;
    if (!done0) begin n_err++; $display("FAIL b2b timeout: dut0 done got 0 want 1"); end
    rect_x = 8'd40; rect_y = 7'd30; rect_w = 8'd2; rect_h = 7'd2; base_addr = 15'd500;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    n_chk++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || ra0 !== 15'd500) begin
      n_err++;
      $display("FAIL b2b dut0 re-accept got busy %b done %b addr %0d want 1 0 500", busy0, done0, ra0);
    end
    n_chk++;
    if (busy1 !== 1'b0 || done1 !== 1'b1 || ra1 !== 15'd305) begin
      n_err++;
      $display("FAIL b2b dut1 got busy %b done %b addr %0d want 0 1 305", busy1, done1, ra1);
    end
    repeat (20) @(negedge clk);
    n_chk++;
    if (done_cnt[0] !== 2 || done_cnt[1] !== 1 || mon0.size() !== 10 || mon0[9].x !== 8'd41 || mon0[9].y !== 7'd31) begin
      n_err++;
      $display("FAIL b2b totals got done %0d/%0d plots %0d want 2/1 and 10 ending (41,31)", done_cnt[0], done_cnt[1], mon0.size());
    end
  endtask

  task automatic test_reset_mid;
    clear_stats();
    @(negedge clk);
    full_screen = 1; base_addr = 15'd0; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 200 && ra0 != 15'd50; i++) @(negedge clk);
    n_chk++;
    if (ra0 !== 15'd50) begin n_err++; $display("FAIL rstmid timeout: rom_addr got %0d want 50", ra0); end
    #2 resetn = 0;
    #1;
    n_chk++;
    if ({ra0, x0, y0, col0, plot0, busy0, done0} !== '0) begin
      n_err++;
      $display("FAIL rstmid dut0 outputs got %h want 0", {ra0, x0, y0, col0, plot0, busy0, done0});
    end
    n_chk++;
    if ({ra1, x1, y1, col1, plot1, busy1, done1} !== '0) begin
      n_err++;
      $display("FAIL rstmid dut1 outputs got %h want 0", {ra1, x1, y1, col1, plot1, busy1, done1});
    end
    repeat (4) @(negedge clk);
    resetn = 1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (done_cnt[0] !== 0 || done_cnt[1] !== 0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid after release got done %0d/%0d busy %b%b want 0/0 00", done_cnt[0], done_cnt[1], busy0, busy1);
    end
  endtask

  task automatic test_random;
    int c0, n, bad, rx, ry, rw, rh, base;
    string msg;
    for (int t = 0; t < 10; t++) begin
      rx = $urandom_range(0, 170);
      ry = $urandom_range(0, 125);
      rw = $urandom_range(1, 12);
      rh = $urandom_range(1, 6);
      base = (t % 3 == 0) ? $urandom_range(32755, 32767) : $urandom_range(0, 32767);
      scan("random", 0, rx, ry, rw, rh, base, 0, c0, n);
      for (int d = 0; d < 2; d++) begin
        bad = plot_diff(d, msg);
        n_chk++;
        if (bad !== 0 || done_cnt[d] !== 1 || done_cyc[d] !== c0 + n + d + 2) begin
          n_err++;
          $display("FAIL random%0d dut%0d (%0d,%0d %0dx%0d base %0d): plots '%s' done %0d at %0d want 1 at %0d",
                   t, d, rx, ry, rw, rh, base, msg, done_cnt[d], done_cyc[d], c0 + n + d + 2);
        end
      end
    end
  endtask

  initial begin
    resetn = 0; start = 0; full_screen = 0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; base_addr = '0;
    for (int i = 0; i < 32768; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    clear_stats();
    test_reset();
    test_full_screen();
    test_rect();
    test_clip();
    test_transparent();
    test_zero();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
